// File: rtl/dc_bsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dc_bsp_pkg
// Description : Board-support defaults shared by the I/O pipe blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dc_bsp_pkg;

    localparam int IO_PIPES_NUM_CHAN    = 4;
    localparam int SHIM_AVST_DATA_WIDTH = 64;
    localparam int IO_PIPE_CNT_WIDTH    = 32;

    // Channel-ID width; a single channel still needs one bit to carry an ID.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IO_PIPE_CHAN_W = chan_w(IO_PIPES_NUM_CHAN);

    typedef logic [IO_PIPE_CHAN_W-1:0] io_pipe_chan_t;

endpackage
`default_nettype wire

// File: rtl/io_pipe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_pipe_rr_arbiter
// Description : Combinational round-robin arbiter; searches from i_rr_ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module io_pipe_rr_arbiter
    import dc_bsp_pkg::*;
#(
    parameter int NUM_CHAN = IO_PIPES_NUM_CHAN,
    parameter int CHAN_W   = chan_w(NUM_CHAN)
) (
    input  logic [NUM_CHAN-1:0] i_req,
    input  logic [CHAN_W-1:0]   i_rr_ptr,
    output logic [NUM_CHAN-1:0] o_grant,
    output logic [CHAN_W-1:0]   o_grant_idx
);

    int w_dist;
    int w_best_dist;

    // Distance 0 is the channel right after the pointer; the smallest distance wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_dist      = 0;
        w_best_dist = NUM_CHAN;
        for (int c = 0; c < NUM_CHAN; c++) begin
            w_dist = (c - int'(i_rr_ptr) - 1 + 2 * NUM_CHAN) % NUM_CHAN;
            if (i_req[c] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_grant     = '0;
                o_grant[c]  = 1'b1;
                o_grant_idx = CHAN_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_pipe_chan_mux.sv
`default_nettype none
// ============================================================================
// Module      : io_pipe_chan_mux
// Description : N-channel AVST egress mux, packet-locked round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module io_pipe_chan_mux
    import dc_bsp_pkg::*;
#(
    parameter int NUM_CHAN   = IO_PIPES_NUM_CHAN,
    parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH,
    parameter int CNT_WIDTH  = IO_PIPE_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_CHAN-1:0]             in_valid,
    output logic [NUM_CHAN-1:0]             in_ready,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_CHAN-1:0]             in_eop,
    input  logic [NUM_CHAN-1:0]             chan_enable,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_eop,
    output logic [chan_w(NUM_CHAN)-1:0]     out_chan,
    input  logic                            cnt_clear,
    output logic [NUM_CHAN*CNT_WIDTH-1:0]   pkt_cnt
);

    localparam int                   CHAN_W    = chan_w(NUM_CHAN);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_eop;
    logic [CHAN_W-1:0]     r_out_chan;
    logic                  r_lock;
    logic [CHAN_W-1:0]     r_lock_chan;
    logic [CHAN_W-1:0]     r_rr_ptr;

    logic                  w_load_ok;
    logic [NUM_CHAN-1:0]   w_arb_grant;
    logic [CHAN_W-1:0]     w_arb_idx;
    logic [CHAN_W-1:0]     w_gnt_idx;
    logic                  w_xfer;
    logic                  w_cnt_inc;

    io_pipe_rr_arbiter #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) u_arb (
        .i_req       (in_valid & chan_enable),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    assign w_load_ok = !r_out_valid || out_ready;
    assign w_gnt_idx = r_lock ? r_lock_chan : w_arb_idx;

    // A held lock ignores enables and other requesters until the eop beat.
    always_comb begin
        in_ready = '0;
        if (reset_n && w_load_ok) begin
            if (r_lock) begin
                in_ready[r_lock_chan] = 1'b1;
            end else begin
                in_ready = w_arb_grant;
            end
        end
    end

    assign w_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_chan  <= '0;
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
            r_rr_ptr    <= CHAN_W'(NUM_CHAN - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt_idx * DATA_WIDTH +: DATA_WIDTH];
            r_out_eop   <= in_eop[w_gnt_idx];
            r_out_chan  <= w_gnt_idx;
            if (in_eop[w_gnt_idx]) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_gnt_idx;
            end else begin
                r_lock      <= 1'b1;
                r_lock_chan <= w_gnt_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_eop   = r_out_eop;
    assign out_chan  = r_out_chan;

    // A packet counts when its last beat leaves the output register.
    assign w_cnt_inc = r_out_valid && out_ready && r_out_eop;

    generate
        for (genvar i = 0; i < NUM_CHAN; i++) begin : g_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (cnt_clear) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc && (r_out_chan == CHAN_W'(i)) && (r_cnt != C_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_io_pipe_chan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_pipe_chan_mux
// Description : Self-checking bench for io_pipe_chan_mux against a packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_pipe_chan_mux;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int CHW = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_eop = '0;
    logic [N-1:0]    chan_enable = '1;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic            out_eop;
    logic [CHW-1:0]  out_chan;
    logic            cnt_clear = 1'b0;
    logic [N*CW-1:0] pkt_cnt;

    always #5 clk = ~clk;

    io_pipe_chan_mux #(
        .NUM_CHAN   (N),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_eop      (in_eop),
        .chan_enable (chan_enable),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_eop     (out_eop),
        .out_chan    (out_chan),
        .cnt_clear   (cnt_clear),
        .pkt_cnt     (pkt_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } beat_t;

    beat_t        q[N][$];
    logic [N-1:0] gate = '1;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           seen[$];
    int           stall2 = 0;

    // Packet-level model: who owns the output, who was served last.
    bit            m_ov;
    bit            m_oe;
    logic [DW-1:0] m_od;
    int            m_oc;
    int            m_lock;
    int            m_last;
    int            m_cnt[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ov = 0; m_oe = 0; m_od = '0; m_oc = 0; m_lock = -1; m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    function automatic int model_grant();
        if (m_lock >= 0) return m_lock;
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (in_valid[c] && chan_enable[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit idle();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
        return !m_ov;
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]          = (q[i].size() != 0) && gate[i];
            in_data[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0].d : '0;
            in_eop[i]            = (q[i].size() != 0) ? q[i][0].e : 1'b0;
        end
    endfunction

    task automatic push_pkt(input int ch, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = $urandom;
            b.e = (k == len - 1);
            q[ch].push_back(b);
        end
    endtask

    // One clock: check handshake, advance the model, check registered outputs.
    task automatic step();
        int g;
        bit lok;
        logic [N-1:0] exp_rdy;
        beat_t b;
        drive();
        #1;
        g = model_grant();
        lok = !m_ov || out_ready;
        exp_rdy = '0;
        if (g >= 0 && lok) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (out_valid && out_ready) seen.push_back(int'(out_chan));
        if (in_valid[2] && !in_ready[2]) stall2++;
        if (cnt_clear) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_ov && out_ready && m_oe && m_cnt[m_oc] < (1 << CW) - 1) begin
            m_cnt[m_oc]++;
        end
        if (g >= 0 && lok && in_valid[g]) begin
            b = q[g].pop_front();
            m_ov = 1; m_od = b.d; m_oe = b.e; m_oc = g;
            if (b.e) begin
                m_lock = -1;
                m_last = g;
            end else begin
                m_lock = g;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("out_data", 64'(out_data), 64'(m_od));
            check("out_eop", 64'(out_eop), 64'(m_oe));
            check("out_chan", 64'(out_chan), 64'(m_oc));
        end
        for (int i = 0; i < N; i++) check("pkt_cnt", 64'(pkt_cnt[i*CW +: CW]), 64'(m_cnt[i]));
    endtask

    task automatic run_idle(input int limit);
        int k = 0;
        while (!idle() && k < limit) begin
            step();
            k++;
        end
        check("drain_timeout", 64'(idle()), 64'd1);
    endtask

    task automatic check_seen(input string name, input int exp[$]);
        check({name, "_len"}, 64'(seen.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            check(name, 64'(seen[i]), 64'(exp[i]));
    endtask

    initial begin
        logic [DW-1:0] held;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_eop", 64'(out_eop), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        reset_n = 1'b1;

        // Four simultaneous single-beat packets are served 0,1,2,3.
        seen.delete();
        for (int c = 0; c < N; c++) push_pkt(c, 1);
        run_idle(30);
        check_seen("t1_order", '{0, 1, 2, 3});
        for (int c = 0; c < N; c++) check("t1_cnt", 64'(pkt_cnt[c*CW +: CW]), 64'd1);

        // Locked ch1 packet blocks ch2 for three cycles.
        seen.delete();
        stall2 = 0;
        push_pkt(1, 3);
        push_pkt(2, 1);
        run_idle(30);
        check_seen("t2_order", '{1, 1, 1, 2});
        check("t2_stall2", 64'(stall2), 64'd3);

        // Disabling ch1 mid-packet still lets the packet finish.
        seen.delete();
        push_pkt(1, 4);
        step();
        chan_enable[1] = 1'b0;
        push_pkt(3, 1);
        push_pkt(1, 1);
        repeat (10) step();
        check_seen("t3_order", '{1, 1, 1, 1, 3});
        check("t3_ch1_left", 64'(q[1].size()), 64'd1);
        chan_enable[1] = 1'b1;
        run_idle(30);

        // Backpressure holds the output beat and all readies low.
        seen.delete();
        push_pkt(0, 4);
        push_pkt(2, 2);
        step();
        out_ready = 1'b0;
        held = out_data;
        repeat (5) begin
            step();
            check("t4_hold_data", 64'(out_data), 64'(held));
            check("t4_hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        run_idle(30);
        check("t4_first", 64'(seen.size() > 0 ? seen[0] : -1), 64'd2);
        check("t4_count", 64'(seen.size()), 64'd6);

        // Counter saturation and clear priority.
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        for (int k = 0; k < 17; k++) push_pkt(0, 1);
        run_idle(100);
        check("t5_sat", 64'(pkt_cnt[0 +: CW]), 64'd15);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        push_pkt(0, 1);
        push_pkt(0, 1);
        step();
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        check("t5_clear_wins", 64'(pkt_cnt[0 +: CW]), 64'd0);
        run_idle(30);
        check("t5_after", 64'(pkt_cnt[0 +: CW]), 64'd1);

        // Reset in the middle of a ch2 packet.
        push_pkt(2, 5);
        push_pkt(0, 1);
        step();
        step();
        check("t6_locked_ch2", 64'(out_chan), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < N; c++) q[c].delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_cnt", 64'(pkt_cnt), 64'd0);
        reset_n = 1'b1;
        seen.delete();
        push_pkt(2, 1);
        push_pkt(0, 1);
        run_idle(30);
        check_seen("t6_order", '{0, 2});

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ch;
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, N - 1);
                if (q[ch].size() < 10) push_pkt(ch, $urandom_range(1, 5));
            end
            gate = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) chan_enable[$urandom_range(0, N - 1)] ^= 1'b1;
            cnt_clear = ($urandom_range(0, 199) == 0);
            step();
        end
        chan_enable = '1;
        gate = '1;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        run_idle(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
